// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg -- shared definitions for the serial CRC-16 transmit encoder.
//   DATA_W   : message word width
//   CRC_W    : checksum width
//   CW_W     : codeword width {data, crc}
//   CRC_POLY : generator polynomial x^16+x^12+x^5+1 (implicit x^16 term)
//   state_e  : encoder FSM states
// ---------------------------------------------------------------------------
package crc_pkg;

    localparam int DATA_W = 16;
    localparam int CRC_W  = 16;
    localparam int CW_W   = DATA_W + CRC_W;

    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/crc_tx_encoder_if.sv
// ---------------------------------------------------------------------------
// crc_tx_encoder_if -- transmitter-side bus of the CRC encoder.
//   dataIn    : message word to encode           (master -> slave)
//   dataValid : dataIn valid this cycle           (master -> slave)
//   CW        : codeword {data, crc}              (slave -> master)
//   CWValid   : one-cycle strobe marking CW valid (slave -> master)
//   Txbusy    : encoder occupied, dataValid ignored while high (slave -> master)
// The encoder uses the slave modport; the word source uses master.
// ---------------------------------------------------------------------------
interface crc_tx_encoder_if #(
    parameter int DATA_W = 16,
    parameter int CRC_W  = 16
);

    logic [DATA_W-1:0]       dataIn;
    logic                    dataValid;
    logic [DATA_W+CRC_W-1:0] CW;
    logic                    CWValid;
    logic                    Txbusy;

    modport master (
        output dataIn,
        output dataValid,
        input  CW,
        input  CWValid,
        input  Txbusy
    );

    modport slave (
        input  dataIn,
        input  dataValid,
        output CW,
        output CWValid,
        output Txbusy
    );

endinterface

// File: rtl/crc16_serial_step.sv
// ---------------------------------------------------------------------------
// crc16_serial_step -- purely combinational one-bit LFSR update of an
// MSB-first CRC (no augmentation: the message bit is folded into feedback).
//   crc      : current remainder
//   data_bit : next message bit, MSB first
//   crc_next : remainder after absorbing data_bit
// ---------------------------------------------------------------------------
module crc16_serial_step #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h1021
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             data_bit,
    output logic [CRC_W-1:0] crc_next
);

    logic fb;

    assign fb       = crc[CRC_W-1] ^ data_bit;
    assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_tx_encoder.sv
// ---------------------------------------------------------------------------
// crc_tx_encoder -- serial CRC-16 (poly 0x1021, init 0, no final XOR)
// transmit encoder. A word accepted in IDLE is shifted MSB-first through the
// LFSR for DATA_W cycles, then presented as CW = {data, crc} with a one-cycle
// CWValid strobe. Throughput is one word per DATA_W+2 cycles.
//   clk : master clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of crc_tx_encoder_if (dataIn, dataValid -> CW, CWValid, Txbusy)
// ---------------------------------------------------------------------------
module crc_tx_encoder
    import crc_pkg::*;
#(
    parameter int DATA_W = crc_pkg::DATA_W,
    parameter int CRC_W  = crc_pkg::CRC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    crc_tx_encoder_if.slave      bus
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e                    state;
    state_e                    state_next;

    logic [DATA_W-1:0]         data_sr;
    logic [DATA_W-1:0]         data_hold;
    logic [CRC_W-1:0]          crc;
    logic [CRC_W-1:0]          crc_next;
    logic [CNT_W-1:0]          bit_cnt;
    logic [DATA_W+CRC_W-1:0]   cw;
    logic                      cw_valid;
    logic                      tx_busy;

    logic                      capture;
    logic                      shift;
    logic                      finish;

    crc16_serial_step #(
        .CRC_W (CRC_W),
        .POLY  (CRC_W'(CRC_POLY))
    ) u_step (
        .crc      (crc),
        .data_bit (data_sr[DATA_W-1]),
        .crc_next (crc_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path through
    // this block leaves one unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.dataValid) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (bit_cnt == CNT_LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // CW/CWValid are loaded on the edge entering DONE from the final LFSR
    // step, so they are valid for exactly the DONE cycle. Txbusy is derived
    // from the next state and registered, keeping dataValid off any
    // combinational path to the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sr   <= '0;
            data_hold <= '0;
            crc       <= '0;
            bit_cnt   <= '0;
            cw        <= '0;
            cw_valid  <= 1'b0;
            tx_busy   <= 1'b0;
        end else begin
            cw_valid <= finish;
            tx_busy  <= (state_next != IDLE);
            if (capture) begin
                data_sr   <= bus.dataIn;
                data_hold <= bus.dataIn;
                crc       <= '0;
                bit_cnt   <= '0;
            end else if (shift) begin
                crc     <= crc_next;
                data_sr <= {data_sr[DATA_W-2:0], 1'b0};
                // Hold at the last count; the next capture clears it anyway.
                if (!finish) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (finish) begin
                cw <= {data_hold, crc_next};
            end
        end
    end

    assign bus.CW      = cw;
    assign bus.CWValid = cw_valid;
    assign bus.Txbusy  = tx_busy;

endmodule
